// File: rtl/sinc3_decim_param.sv
// Third-order sinc decimator for a single-bit sigma-delta stream.
// Runtime 2^k ratio, auto scaling, offset, saturation, settle suppression.
module sinc3_decim_param #(
  parameter int OUT_W        = 16,
  parameter int DEC_MIN_LOG2 = 4,
  parameter int DEC_MAX_LOG2 = 12,
  parameter int SETTLE       = 3
) (
  input  logic             mclk1,
  input  logic             reset,
  input  logic             mdata1,
  input  logic             mdata_vld,
  input  logic [3:0]       dec_log2,
  input  logic [OUT_W-1:0] offset,
  output logic [OUT_W-1:0] data_out,
  output logic             data_valid,
  output logic             sat_flag,
  output logic [3:0]       k_active
);

  localparam int ACC_W = 3*DEC_MAX_LOG2+1;
  localparam int CNT_W = DEC_MAX_LOG2;
  localparam int ST_W  = (SETTLE > 0) ? $clog2(SETTLE+1) : 1;
  localparam int RES_W = OUT_W+2;
  localparam logic signed [RES_W-1:0] SAT_HI =
    RES_W'((1 << (OUT_W-1)) - 1);
  localparam logic signed [RES_W-1:0] SAT_LO =
    RES_W'(-(1 << (OUT_W-1)));

  function automatic logic [3:0] clamp_k(input logic [3:0] d);
    if (int'(d) < DEC_MIN_LOG2) return 4'(DEC_MIN_LOG2);
    if (int'(d) > DEC_MAX_LOG2) return 4'(DEC_MAX_LOG2);
    return d;
  endfunction

  logic [3:0]       k_req;
  logic             restart;
  logic [ACC_W-1:0] acc1, acc2, acc3;
  logic [ACC_W-1:0] acc3_d, d1_d, d2_d;
  logic [ACC_W-1:0] d1, d2, d3;
  logic [ACC_W-1:0] raw;
  logic             raw_vld;
  logic             dec_stb;
  logic [CNT_W-1:0] cnt, cnt_mask;
  logic             cnt_last;
  logic [ST_W-1:0]  settle;

  int                     shamt;
  logic [ACC_W+OUT_W:0]   ext;
  logic [OUT_W:0]         scaled;
  logic signed [RES_W-1:0] res;
  logic [OUT_W-1:0]       out_word;
  logic                   clipped;
  logic                   unused_ext;

  assign k_req    = clamp_k(dec_log2);
  assign restart  = (k_req != k_active);
  assign cnt_mask = ~({CNT_W{1'b1}} << k_active);
  assign cnt_last = (cnt == cnt_mask);

  assign d1 = acc3 - acc3_d;
  assign d2 = d1 - d1_d;
  assign d3 = d2 - d2_d;

  // Shift places the R^3 full scale at the top of the output word.
  always_comb begin
    shamt = 3*int'(k_active) + 1 - OUT_W;
    ext = {{(OUT_W+1){1'b0}}, raw};
    if (shamt >= 0) ext = ext >> shamt;
    else ext = ext << (-shamt);
    scaled = ext[OUT_W:0];
    res = $signed({1'b0, scaled}) -
          $signed({{2{offset[OUT_W-1]}}, offset});
    out_word = res[OUT_W-1:0];
    clipped  = 1'b0;
    if (res > SAT_HI) begin
      out_word = SAT_HI[OUT_W-1:0];
      clipped  = 1'b1;
    end else if (res < SAT_LO) begin
      out_word = SAT_LO[OUT_W-1:0];
      clipped  = 1'b1;
    end
  end

  assign unused_ext = ^ext[ACC_W+OUT_W:OUT_W+1];

  always_ff @(posedge mclk1) begin
    if (reset) begin
      acc1       <= '0;
      acc2       <= '0;
      acc3       <= '0;
      acc3_d     <= '0;
      d1_d       <= '0;
      d2_d       <= '0;
      raw        <= '0;
      raw_vld    <= 1'b0;
      dec_stb    <= 1'b0;
      cnt        <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      sat_flag   <= 1'b0;
      k_active   <= k_req;
      settle     <= ST_W'(SETTLE);
    end else if (restart) begin
      acc1       <= '0;
      acc2       <= '0;
      acc3       <= '0;
      acc3_d     <= '0;
      d1_d       <= '0;
      d2_d       <= '0;
      raw        <= '0;
      raw_vld    <= 1'b0;
      dec_stb    <= 1'b0;
      cnt        <= '0;
      data_valid <= 1'b0;
      k_active   <= k_req;
      settle     <= ST_W'(SETTLE);
    end else begin
      data_valid <= 1'b0;
      if (mdata_vld) begin
        acc1 <= acc1 + {{(ACC_W-1){1'b0}}, mdata1};
        acc2 <= acc2 + acc1;
        acc3 <= acc3 + acc2;
        cnt  <= cnt_last ? '0 : cnt + CNT_W'(1);
      end
      dec_stb <= mdata_vld & cnt_last;
      raw_vld <= dec_stb;
      if (dec_stb) begin
        acc3_d <= acc3;
        d1_d   <= d1;
        d2_d   <= d2;
        raw    <= d3;
      end
      if (raw_vld) begin
        if (settle != '0) begin
          settle <= settle - ST_W'(1);
        end else begin
          data_out   <= out_word;
          data_valid <= 1'b1;
          if (clipped) sat_flag <= 1'b1;
        end
      end
    end
  end

endmodule
